// File: rtl/pwm_duty_ctrl.sv
// Duty-cycle controller: debounces inc/dec button levels and turns presses and holds
// into saturating duty steps (0..MAX_DUTY) with hold-to-auto-repeat.
module pwm_duty_ctrl #(
    parameter int INITIAL_DUTY    = 5,
    parameter int MAX_DUTY        = 10,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 20000,
    parameter int DUTY_W          = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_in,
    input  logic              dec_in,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_update,
    output logic              at_min,
    output logic              at_max
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HC_N = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HC_W = (HC_N > 2) ? $clog2(HC_N) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ZERO   = DB_W'(0);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HC_W-1:0]   RD_LAST   = HC_W'(REPEAT_DELAY - 1);
    localparam logic [HC_W-1:0]   RP_LAST   = HC_W'(REPEAT_PERIOD - 1);
    localparam logic [HC_W-1:0]   HC_ZERO   = HC_W'(0);
    localparam logic [HC_W-1:0]   HC_ONE    = HC_W'(1);
    localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(MAX_DUTY);
    localparam logic [DUTY_W-1:0] DUTY_INIT = DUTY_W'(INITIAL_DUTY);
    localparam logic [DUTY_W-1:0] DUTY_ZERO = DUTY_W'(0);
    localparam logic [DUTY_W-1:0] DUTY_ONE  = DUTY_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCK   = 2'd3
    } state_t;

    // Bit 0 is the increase button, bit 1 the decrease button.
    logic [1:0]            raw_s;
    logic [1:0]            rise_s;
    logic [1:0]            db_q, db_d, db_prev_q;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    state_t                state_q, state_d;
    logic [HC_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic                  dir_q, dir_d;
    logic                  active_s, other_s;
    logic                  step_q, step_d;
    logic                  step_dn_q, step_dn_d;
    logic [DUTY_W-1:0]     duty_q, duty_d;
    logic                  upd_q, upd_d;

    assign raw_s    = {dec_in, inc_in};
    assign rise_s   = db_q & ~db_prev_q;
    assign active_s = dir_q ? db_q[1] : db_q[0];
    assign other_s  = dir_q ? db_q[0] : db_q[1];

    // Debounce: a level flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (raw_s[i] == db_q[i]) begin
                db_cnt_d[i] = DB_ZERO;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_d[i]     = raw_s[i];
                db_cnt_d[i] = DB_ZERO;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
            end
        end
    end

    // Press/hold/repeat state machine; a step decided here is applied one edge later.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        dir_d      = dir_q;
        step_d     = 1'b0;
        step_dn_d  = dir_q;
        case (state_q)
            ST_IDLE: begin
                hold_cnt_d = HC_ZERO;
                if (rise_s == 2'b11) begin
                    state_d = ST_LOCK;
                end else if (rise_s != 2'b00) begin
                    if ((rise_s[0] && db_q[1]) || (rise_s[1] && db_q[0])) begin
                        state_d = ST_LOCK;
                    end else begin
                        state_d   = ST_HOLD;
                        dir_d     = rise_s[1];
                        step_d    = 1'b1;
                        step_dn_d = rise_s[1];
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!active_s) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = HC_ZERO;
                end else if (other_s) begin
                    state_d    = ST_LOCK;
                    hold_cnt_d = HC_ZERO;
                end else if (hold_cnt_q == ((state_q == ST_HOLD) ? RD_LAST : RP_LAST)) begin
                    state_d    = ST_REPEAT;
                    hold_cnt_d = HC_ZERO;
                    step_d     = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_ONE;
                end
            end
            ST_LOCK: begin
                hold_cnt_d = HC_ZERO;
                if (db_q == 2'b00) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCK;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = HC_ZERO;
            end
        endcase
    end

    // Saturating duty update; the pulse only marks a real change of value.
    always_comb begin
        duty_d = duty_q;
        if (step_q) begin
            if (step_dn_q) begin
                if (duty_q != DUTY_ZERO) begin
                    duty_d = duty_q - DUTY_ONE;
                end else begin
                    duty_d = duty_q;
                end
            end else begin
                if (duty_q < DUTY_MAX) begin
                    duty_d = duty_q + DUTY_ONE;
                end else begin
                    duty_d = duty_q;
                end
            end
        end else begin
            duty_d = duty_q;
        end
        upd_d = (duty_d != duty_q);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q       <= 2'b00;
            db_prev_q  <= 2'b00;
            db_cnt_q   <= {2{DB_ZERO}};
            state_q    <= ST_IDLE;
            hold_cnt_q <= HC_ZERO;
            dir_q      <= 1'b0;
            step_q     <= 1'b0;
            step_dn_q  <= 1'b0;
            duty_q     <= DUTY_INIT;
            upd_q      <= 1'b0;
        end else begin
            db_q       <= db_d;
            db_prev_q  <= db_q;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            step_dn_q  <= step_dn_d;
            duty_q     <= duty_d;
            upd_q      <= upd_d;
        end
    end

    assign duty        = duty_q;
    assign duty_update = upd_q;
    assign at_min      = (duty_q == DUTY_ZERO);
    assign at_max      = (duty_q == DUTY_MAX);

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Scoreboard bench for pwm_duty_ctrl: a time-based reference model predicts every duty
// change; a monitor pops expectations whenever the DUT pulses duty_update.
module tb_pwm_duty_ctrl;

    localparam int D     = 4;
    localparam int RD    = 20;
    localparam int RP    = 8;
    localparam int MAXD  = 10;
    localparam int INIT  = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inc_in = 1'b0;
    logic       dec_in = 1'b0;
    logic [3:0] duty;
    logic       duty_update;
    logic       at_min;
    logic       at_max;

    int errors = 0;
    int checks = 0;

    pwm_duty_ctrl #(
        .INITIAL_DUTY(INIT), .MAX_DUTY(MAXD), .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .DUTY_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .inc_in(inc_in), .dec_in(dec_in),
        .duty(duty), .duty_update(duty_update), .at_min(at_min), .at_max(at_max)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int cyc; int val; } upd_t;
    upd_t q[$];
    int   cyc = 0;
    int   duty_m = INIT;
    bit [1:0] db_m, db_pm, raw_pm;
    int   t_chg [2];
    bit   pend, pend_dn;
    int   mode_m;   // 0 idle, 1 holding, 2 locked
    int   hdir, hstart;

    always @(posedge clk or negedge rst_n) begin
        bit [1:0] raw, rise, nd;
        int nv, el;
        if (!rst_n) begin
            duty_m = INIT; db_m = 2'b00; db_pm = 2'b00; raw_pm = 2'b00;
            t_chg[0] = 0; t_chg[1] = 0; pend = 1'b0; mode_m = 0;
            q.delete();
        end else begin
            cyc++;
            if (pend) begin
                if (pend_dn) nv = (duty_m > 0) ? duty_m - 1 : 0;
                else         nv = (duty_m < MAXD) ? duty_m + 1 : MAXD;
                if (nv != duty_m) begin
                    q.push_back('{cyc, nv});
                    duty_m = nv;
                end
                pend = 1'b0;
            end
            rise = db_m & ~db_pm;
            case (mode_m)
                0: if (rise == 2'b11) mode_m = 2;
                   else if (rise != 2'b00) begin
                       hdir = rise[1] ? 1 : 0;
                       if (db_m[1-hdir]) mode_m = 2;
                       else begin
                           mode_m = 1; hstart = cyc; pend = 1'b1; pend_dn = (hdir == 1);
                       end
                   end
                1: begin
                       el = cyc - hstart;
                       if (!db_m[hdir]) mode_m = 0;
                       else if (db_m[1-hdir]) mode_m = 2;
                       else if (el == RD || (el > RD && (el - RD) % RP == 0)) begin
                           pend = 1'b1; pend_dn = (hdir == 1);
                       end
                   end
                default: if (db_m == 2'b00) mode_m = 0;
            endcase
            raw = {dec_in, inc_in};
            nd  = db_m;
            for (int i = 0; i < 2; i++) begin
                if (raw[i] != raw_pm[i]) t_chg[i] = cyc;
                if (raw[i] != db_m[i] && (cyc - t_chg[i] + 1) >= D) nd[i] = raw[i];
            end
            raw_pm = raw; db_pm = db_m; db_m = nd;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        upd_t u;
        if (rst_n === 1'b1) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                u = q.pop_front();
                chk("missed_update_cycle", 32'(cyc), 32'(u.cyc));
            end
            chk("duty", 32'(duty), 32'(duty_m));
            chk("at_min", 32'(at_min), 32'(duty_m == 0));
            chk("at_max", 32'(at_max), 32'(duty_m == MAXD));
            if (duty_update === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_update", 32'(duty_update), 32'd0);
                end else begin
                    u = q.pop_front();
                    chk("update_cycle", 32'(cyc), 32'(u.cyc));
                    chk("update_duty", 32'(duty), 32'(u.val));
                end
            end else if (duty_update !== 1'b0) begin
                chk("update_known", 32'(duty_update), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic i, input logic d, input int n);
        inc_in = i;
        dec_in = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_state(input string name, input int exp_duty);
        #1;
        chk({name, "_duty"}, 32'(duty), 32'(exp_duty));
        chk({name, "_at_min"}, 32'(at_min), 32'(exp_duty == 0));
        chk({name, "_at_max"}, 32'(at_max), 32'(exp_duty == MAXD));
    endtask

    initial begin
        int mode, len, len2;
        repeat (3) @(negedge clk);
        chk_state("reset", INIT);
        chk("reset_update", 32'(duty_update), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 1'b0, 10); drive(1'b0, 1'b0, 10);
        chk_state("single_press", 6);
        drive(1'b1, 1'b0, 3);  drive(1'b0, 1'b0, 10);
        chk_state("glitch", 6);
        drive(1'b0, 1'b1, 60); drive(1'b0, 1'b0, 12);
        chk_state("hold_dec", 0);
        drive(1'b1, 1'b0, 120); drive(1'b0, 1'b0, 12);
        chk_state("hold_inc", MAXD);
        drive(1'b1, 1'b0, 10); drive(1'b0, 1'b0, 10);
        chk_state("saturate", MAXD);

        drive(1'b0, 1'b1, 28);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_duty", 32'(duty), 32'(INIT));
        chk("async_reset_update", 32'(duty_update), 32'd0);
        chk("async_reset_flags", 32'({at_min, at_max}), 32'd0);
        @(negedge clk);
        inc_in = 1'b0; dec_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 30);
        chk_state("after_reset", INIT);

        drive(1'b1, 1'b1, 30); drive(1'b0, 1'b0, 10);
        chk_state("both_locked", INIT);
        drive(1'b1, 1'b0, 10); drive(1'b0, 1'b0, 10);
        chk_state("after_lock", INIT + 1);

        for (int k = 0; k < 200; k++) begin
            mode = $urandom_range(0, 5);
            len  = $urandom_range(1, 45);
            len2 = $urandom_range(1, 30);
            case (mode)
                0: drive(1'b0, 1'b0, len);
                1: drive(1'b1, 1'b0, len);
                2: drive(1'b0, 1'b1, len);
                3: drive(1'b1, 1'b1, len);
                4: begin drive(1'b1, 1'b0, len); drive(1'b1, 1'b1, len2); end
                default: begin drive(1'b0, 1'b1, $urandom_range(1, D)); drive(1'b0, 1'b0, len2); end
            endcase
        end
        drive(1'b0, 1'b0, 80);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
